div_arbiter: RTL and testbench
==============================

# div_arbiter

Round-robin arbiter and sequencer that shares one sequential NBIT-bit divider core between two requesters. It accepts one operand pair at a time over a valid/ready handshake and issues a single-cycle start to the divider. It waits for the divider's done pulse, with a watchdog timeout, and returns quotient and remainder to the requester that issued the operation. It sits between the two client blocks and the divider datapath/controller pair.

## Interface
- NBIT, 16: operand, quotient and remainder width.
- TIMEOUT, 64: maximum WAIT cycles before an operation is aborted. Must be ≥ 2 and fit in 8 bits.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- req0_valid / req1_valid  in  1  requester k has an operand pair.
- req0_ready / req1_ready  out  1  arbiter accepts requester k this cycle; combinational.
- req0_a, req0_b / req1_a, req1_b  in  NBIT  dividend and divisor.
- rsp0_valid / rsp1_valid  out  1  result for requester k is available.
- rsp0_ready / rsp1_ready  in  1  requester k consumes its result.
- rsp_q  out  NBIT  quotient, shared by both requesters; qualified by rspk_valid.
- rsp_r  out  NBIT  remainder, shared; qualified by rspk_valid.
- rsp_err  out  1  result invalid (timeout or divide-by-zero).
- div_start  out  1  one-cycle start pulse to the divider.
- div_a, div_b  out  NBIT  operands to the divider; held stable from ISSUE through WAIT.
- div_done  in  1  divider completion pulse; honoured only in WAIT.
- div_q, div_r  in  NBIT  divider results; sampled on div_done.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Registers: state, owner (1 bit), prio (1 bit), opa, opb, timer (8 bits), rsp_q, rsp_r, rsp_err.
- IDLE:
  - Winner = prio if req[prio]_valid, else the other requester if its valid is high.
  - Only the winner sees reqk_ready=1; readies are 0 in every other state.
  - On valid&ready, latch a/b into opa/opb, set owner = winner, and go to ISSUE.
- ISSUE: div_start=1 for exactly one cycle; timer cleared; go to WAIT.
- WAIT:
  - timer increments each cycle.
  - On div_done: rsp_q=div_q, rsp_r=div_r, rsp_err=0; go to RESP.
  - If timer == TIMEOUT-1 with no div_done: rsp_q = all ones, rsp_r = 0, rsp_err = 1; go to RESP.
  - div_done takes priority over a simultaneous timeout.
- RESP:
  - rsp[owner]_valid=1; rsp_q, rsp_r and rsp_err held constant.
  - On rsp[owner]_ready: prio = ~owner; go to IDLE.
  - The other requester's rsp_ready is ignored.
- div_a/div_b always drive opa/opb.
- div_done received outside WAIT is ignored.
- Back-to-back operations: after RESP completes, the next acceptance happens in IDLE on the following cycle. Minimum spacing is one IDLE cycle.
- Round-robin guarantee: with both requesters valid continuously, grants strictly alternate.

## Timing
- Reset values: state=IDLE, prio=0, owner=0, all ready/valid outputs 0, div_start=0, rsp_q=rsp_r=0, rsp_err=0, opa=opb=0, timer=0.
- Reset mid-operation aborts immediately. No response is produced; the divider must be reset by the same reset.
- Accept at edge N. div_start is high in cycle N+1. WAIT starts at N+2.
- div_done sampled at edge D gives rsp_valid high from cycle D+1.
- Latency, acceptance to rsp_valid = divider latency + 2 cycles.
- Timeout: rsp_valid is raised TIMEOUT+2 cycles after acceptance.

## Configuration
- DIV_ZERO_CHECK_EN defined:
  - In IDLE, an accepted request with b==0 goes directly to RESP with rsp_q = all ones, rsp_r = a, rsp_err=1.
  - div_start is not pulsed; rsp_valid is high in the cycle after acceptance.
- DIV_ZERO_CHECK_EN undefined:
  - b==0 is issued to the divider like any other operand pair.
  - The result is whatever the divider returns; err is 0 unless a timeout occurs.

## Test plan
- req0 a=100, b=7; divider model done 18 cycles after start → div_start one cycle after accept; rsp0_valid with q=14, r=2, err=0; rsp1_valid stays 0.
- req0 and req1 both valid continuously (a=50/b=5, a=9/b=4) → grants alternate 0,1,0,1; responses q=10 r=0 and q=2 r=1 to the correct owners.
- Divider model never pulses done, TIMEOUT=64 → rsp_valid 66 cycles after accept with q=0xFFFF, r=0, err=1; next request served normally.
- Hold rsp0_ready low for 10 cycles in RESP → rsp0_valid, q and r stable; req1_ready stays 0; stray div_done pulses ignored.
- b=0, a=33 → with DIV_ZERO_CHECK_EN: no div_start, next-cycle response q=0xFFFF r=33 err=1; without the macro: div_start issued.
- Assert reset during WAIT → all outputs return to reset values asynchronously; after release, a req1-only request is granted in the first IDLE cycle.

Source files
------------

// File: rtl/div_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the shared divider.
// The slave modport is the arbiter's view; master is the surrounding clients/divider.
interface div_arbiter_if #(
  parameter int NBIT = 16
);
  logic            req0_valid;
  logic            req0_ready;
  logic [NBIT-1:0] req0_a;
  logic [NBIT-1:0] req0_b;
  logic            req1_valid;
  logic            req1_ready;
  logic [NBIT-1:0] req1_a;
  logic [NBIT-1:0] req1_b;
  logic            rsp0_valid;
  logic            rsp0_ready;
  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [NBIT-1:0] rsp_q;
  logic [NBIT-1:0] rsp_r;
  logic            rsp_err;
  logic            div_start;
  logic [NBIT-1:0] div_a;
  logic [NBIT-1:0] div_b;
  logic            div_done;
  logic [NBIT-1:0] div_q;
  logic [NBIT-1:0] div_r;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, div_done, div_q, div_r,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_q, rsp_r, rsp_err, div_start, div_a, div_b
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, div_done, div_q, div_r,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_q, rsp_r, rsp_err, div_start, div_a, div_b
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential divider between two requesters, with watchdog.
// Optional macro DIV_ZERO_CHECK_EN answers b==0 requests directly without using the divider.
module div_arbiter #(
  parameter int NBIT    = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  div_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next;
  logic            r_owner;
  logic            r_prio;
  logic [NBIT-1:0] r_opA;
  logic [NBIT-1:0] r_opB;
  logic [7:0]      r_timer;
  logic [NBIT-1:0] r_rspQ;
  logic [NBIT-1:0] r_rspR;
  logic            r_rspErr;

  logic            w_winner;
  logic            w_accept;
  logic [NBIT-1:0] w_selA;
  logic [NBIT-1:0] w_selB;
  logic            w_zeroDiv;
  logic            w_ownerReady;
  logic            w_timeout;

  // The priority holder wins if it is asking; otherwise the other side gets the slot.
  always_comb begin
    w_winner = r_prio;
    if (!(r_prio ? bus.req1_valid : bus.req0_valid)) w_winner = ~r_prio;
    w_accept     = (r_state == IDLE) && (bus.req0_valid || bus.req1_valid);
    w_selA       = w_winner ? bus.req1_a : bus.req0_a;
    w_selB       = w_winner ? bus.req1_b : bus.req0_b;
    w_ownerReady = r_owner ? bus.rsp1_ready : bus.rsp0_ready;
    w_timeout    = (r_timer == TIMER_LAST);
`ifdef DIV_ZERO_CHECK_EN
    w_zeroDiv    = (w_selB == '0);
`else
    w_zeroDiv    = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.div_start  = 1'b0;
    case (r_state)
      IDLE: begin
        bus.req0_ready = w_accept && !w_winner;
        bus.req1_ready = w_accept &&  w_winner;
        if (w_accept) w_next = w_zeroDiv ? RESP : ISSUE;
      end
      ISSUE: begin
        bus.div_start = 1'b1;
        w_next        = WAIT;
      end
      WAIT: begin
        if (bus.div_done || w_timeout) w_next = RESP;
      end
      RESP: begin
        bus.rsp0_valid = !r_owner;
        bus.rsp1_valid =  r_owner;
        if (w_ownerReady) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, watchdog and result registers; results stay frozen through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner  <= 1'b0;
      r_prio   <= 1'b0;
      r_opA    <= '0;
      r_opB    <= '0;
      r_timer  <= '0;
      r_rspQ   <= '0;
      r_rspR   <= '0;
      r_rspErr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_opA   <= w_selA;
            r_opB   <= w_selB;
            r_owner <= w_winner;
            if (w_zeroDiv) begin
              r_rspQ   <= '1;
              r_rspR   <= w_selA;
              r_rspErr <= 1'b1;
            end
          end
        end
        ISSUE: r_timer <= '0;
        WAIT: begin
          r_timer <= r_timer + 8'd1;
          if (bus.div_done) begin
            r_rspQ   <= bus.div_q;
            r_rspR   <= bus.div_r;
            r_rspErr <= 1'b0;
          end else if (w_timeout) begin
            r_rspQ   <= '1;
            r_rspR   <= '0;
            r_rspErr <= 1'b1;
          end
        end
        RESP: begin
          if (w_ownerReady) r_prio <= ~r_owner;
        end
        default: ;
      endcase
    end
  end

  assign bus.div_a   = r_opA;
  assign bus.div_b   = r_opB;
  assign bus.rsp_q   = r_rspQ;
  assign bus.rsp_r   = r_rspR;
  assign bus.rsp_err = r_rspErr;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: directed vector table, randomized ops against a
// round-robin/arithmetic reference model, and an asynchronous reset during WAIT.
module tb_div_arbiter;

  localparam int NBIT    = 16;
  localparam int TIMEOUT = 64;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic clk;
  logic reset;

  div_arbiter_if #(.NBIT(NBIT)) bus ();

  div_arbiter #(.NBIT(NBIT), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  bit mPrio      = 1'b0;

  // Divider stand-in: answers a/b after a programmable latency, or never.
  int          divLat    = 4;
  bit          divNever  = 1'b0;
  bit          strayDone = 1'b0;
  logic        mActive;
  int          mCnt;
  logic [15:0] mQ;
  logic [15:0] mR;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mActive <= 1'b0;
      mCnt    <= 0;
      mQ      <= '0;
      mR      <= '0;
    end else if (bus.div_start) begin
      mActive <= !divNever;
      mCnt    <= divLat - 1;
      mQ      <= (bus.div_b == 0) ? 16'hFFFF : bus.div_a / bus.div_b;
      mR      <= (bus.div_b == 0) ? bus.div_a : bus.div_a % bus.div_b;
    end else if (mActive) begin
      if (mCnt == 0) mActive <= 1'b0;
      else           mCnt    <= mCnt - 1;
    end
  end

  assign bus.div_done = (mActive && mCnt == 0) || strayDone;
  assign bus.div_q    = mQ;
  assign bus.div_r    = mR;

  typedef struct {
    bit          v0;
    bit          v1;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [15:0] a1;
    logic [15:0] b1;
    int          lat;
    int          hold;
    bit          keep;
    bit          expOwner;
    logic [15:0] expQ;
    logic [15:0] expR;
    bit          expErr;
    int          expLat;
    bit          expStart;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input bit v0, input bit v1, input logic [15:0] a0, input logic [15:0] b0,
                               input logic [15:0] a1, input logic [15:0] b1);
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.req0_a     = a0;
    bus.req0_b     = b0;
    bus.req1_a     = a1;
    bus.req1_b     = b1;
  endtask

  task automatic doOp(input bit v0, input bit v1, input logic [15:0] a0, input logic [15:0] b0,
                      input logic [15:0] a1, input logic [15:0] b1, input int lat, input int hold,
                      input bit keep, input bit expOwner, input logic [15:0] expQ,
                      input logic [15:0] expR, input bit expErr, input int expLat, input bit expStart);
    int got;
    int starts;
    int startK;
    @(negedge clk);
    divLat   = (lat < 1) ? 1 : lat;
    divNever = (lat < 0);
    applyStimulus(v0, v1, a0, b0, a1, b1);
    #1;
    checkOutput("grantReady", {62'd0, bus.req1_ready, bus.req0_ready}, {62'd0, expOwner, !expOwner});
    @(posedge clk);
    #1;
    if (!keep) applyStimulus(1'b0, 1'b0, a0, b0, a1, b1);
    got    = -1;
    starts = 0;
    startK = -1;
    for (int k = 1; k <= TIMEOUT + 40 && got < 0; k++) begin
      @(negedge clk);
      if (bus.div_start) begin
        starts++;
        if (startK < 0) startK = k;
      end
      if (bus.rsp0_valid || bus.rsp1_valid) got = k;
    end
    checkOutput("latency", 64'(got), 64'(expLat));
    checkOutput("startCount", 64'(starts), expStart ? 64'd1 : 64'd0);
    if (expStart) checkOutput("startCycle", 64'(startK), 64'd1);
    if (got < 0) return;
    checkOutput("rspOwner", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, {62'd0, expOwner, !expOwner});
    checkOutput("rspQ", 64'(bus.rsp_q), 64'(expQ));
    checkOutput("rspR", 64'(bus.rsp_r), 64'(expR));
    checkOutput("rspErr", 64'(bus.rsp_err), 64'(expErr));
    for (int h = 0; h < hold; h++) begin
      strayDone = (h % 2 == 0);
      if (expOwner) bus.rsp0_ready = 1'b1;
      else          bus.rsp1_ready = 1'b1;
      @(negedge clk);
      checkOutput("holdStable",
                  {29'd0, bus.rsp1_valid, bus.rsp0_valid, bus.req1_ready, bus.req0_ready,
                   bus.rsp_err, bus.rsp_q, bus.rsp_r},
                  {29'd0, expOwner, !expOwner, 2'b00, expErr, expQ, expR});
    end
    strayDone      = 1'b0;
    bus.rsp0_ready = !expOwner;
    bus.rsp1_ready =  expOwner;
    @(posedge clk);
    #1;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    checkOutput("rspDrop", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd0);
    mPrio = !expOwner;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit          v0, v1, owner;
    logic [15:0] a0, b0, a1, b1, opA, opB, eQ, eR;
    bit          eErr, eStart;
    int          lat, eLat;

    vecs[0] = '{1, 1, 16'd50, 16'd5, 16'd9, 16'd4, 5, 0, 1, 0, 16'd10, 16'd0, 0, 7, 1};
    vecs[1] = '{1, 1, 16'd50, 16'd5, 16'd9, 16'd4, 5, 0, 1, 1, 16'd2, 16'd1, 0, 7, 1};
    vecs[2] = '{1, 1, 16'd50, 16'd5, 16'd9, 16'd4, 5, 0, 1, 0, 16'd10, 16'd0, 0, 7, 1};
    vecs[3] = '{1, 1, 16'd50, 16'd5, 16'd9, 16'd4, 3, 0, 1, 1, 16'd2, 16'd1, 0, 5, 1};
    vecs[4] = '{1, 0, 16'd100, 16'd7, 16'd0, 16'd0, 18, 0, 0, 0, 16'd14, 16'd2, 0, 20, 1};
    vecs[5] = '{1, 0, 16'd1000, 16'd3, 16'd0, 16'd0, -1, 0, 0, 0, 16'hFFFF, 16'd0, 1, TIMEOUT + 2, 1};
    vecs[6] = '{0, 1, 16'd0, 16'd0, 16'd77, 16'd10, 3, 0, 0, 1, 16'd7, 16'd7, 0, 5, 1};
    vecs[7] = '{1, 1, 16'd200, 16'd9, 16'd5, 16'd2, 4, 10, 1, 0, 16'd22, 16'd2, 0, 6, 1};
    vecs[8] = '{0, 1, 16'd0, 16'd0, 16'd33, 16'd0, 6, 2, 0, 1, 16'hFFFF, 16'd33, ZC,
                ZC ? 1 : 8, !ZC};

    reset          = 1'b1;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    #12;
    checkOutput("resetCtrl", {58'd0, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                              bus.div_start, bus.rsp_err}, 64'd0);
    checkOutput("resetData", {bus.rsp_q, bus.rsp_r, bus.div_a, bus.div_b}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed vectors");
    for (int i = 0; i < 9; i++) begin
      doOp(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1, vecs[i].lat,
           vecs[i].hold, vecs[i].keep, vecs[i].expOwner, vecs[i].expQ, vecs[i].expR,
           vecs[i].expErr, vecs[i].expLat, vecs[i].expStart);
    end

    $display("[TB] randomized operations");
    for (int i = 0; i < 25; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      a0 = 16'($urandom);
      a1 = 16'($urandom);
      b0 = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      b1 = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 20));
      owner = mPrio;
      if (!(owner ? v1 : v0)) owner = !owner;
      opA = owner ? a1 : a0;
      opB = owner ? b1 : b0;
      if (ZC && opB == 0) begin
        eQ = 16'hFFFF; eR = opA; eErr = 1'b1; eLat = 1; eStart = 1'b0;
      end else if (lat < 0) begin
        eQ = 16'hFFFF; eR = 16'd0; eErr = 1'b1; eLat = TIMEOUT + 2; eStart = 1'b1;
      end else begin
        eQ = (opB == 0) ? 16'hFFFF : opA / opB;
        eR = (opB == 0) ? opA : opA % opB;
        eErr = 1'b0; eLat = lat + 2; eStart = 1'b1;
      end
      doOp(v0, v1, a0, b0, a1, b1, lat, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           owner, eQ, eR, eErr, eLat, eStart);
    end

    $display("[TB] reset during WAIT");
    @(negedge clk);
    divNever = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'd10, 16'd3, 16'd0, 16'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midResetCtrl", {58'd0, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                                 bus.div_start, bus.rsp_err}, 64'd0);
    checkOutput("midResetData", {bus.rsp_q, bus.rsp_r, bus.div_a, bus.div_b}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    mPrio = 1'b0;
    doOp(1'b0, 1'b1, 16'd0, 16'd0, 16'd45, 16'd6, 4, 1, 1'b0, 1'b1, 16'd7, 16'd3, 1'b0, 6, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
